// File: rtl/agex_stage_pkg.sv
// Shared constants for the AGEX stage: opcodes, format types, latch layouts and MUL states.
package agex_stage_pkg;

    localparam int DBITS      = 32;
    localparam int REGNOBITS  = 5;
    localparam int IOPBITS    = 6;
    localparam int TYPENOBITS = 3;
    localparam int SHBITS     = $clog2(DBITS);
    localparam int CNTBITS    = $clog2(DBITS);

    localparam logic [IOPBITS-1:0] OP_INVALID = 6'd0;
    localparam logic [IOPBITS-1:0] OP_ADD     = 6'd1;
    localparam logic [IOPBITS-1:0] OP_SUB     = 6'd2;
    localparam logic [IOPBITS-1:0] OP_AND     = 6'd3;
    localparam logic [IOPBITS-1:0] OP_OR      = 6'd4;
    localparam logic [IOPBITS-1:0] OP_XOR     = 6'd5;
    localparam logic [IOPBITS-1:0] OP_SLT     = 6'd6;
    localparam logic [IOPBITS-1:0] OP_SLTU    = 6'd7;
    localparam logic [IOPBITS-1:0] OP_SLL     = 6'd8;
    localparam logic [IOPBITS-1:0] OP_SRL     = 6'd9;
    localparam logic [IOPBITS-1:0] OP_SRA     = 6'd10;
    localparam logic [IOPBITS-1:0] OP_ADDI    = 6'd11;
    localparam logic [IOPBITS-1:0] OP_ANDI    = 6'd12;
    localparam logic [IOPBITS-1:0] OP_ORI     = 6'd13;
    localparam logic [IOPBITS-1:0] OP_XORI    = 6'd14;
    localparam logic [IOPBITS-1:0] OP_SLTI    = 6'd15;
    localparam logic [IOPBITS-1:0] OP_SLTIU   = 6'd16;
    localparam logic [IOPBITS-1:0] OP_SLLI    = 6'd17;
    localparam logic [IOPBITS-1:0] OP_SRLI    = 6'd18;
    localparam logic [IOPBITS-1:0] OP_SRAI    = 6'd19;
    localparam logic [IOPBITS-1:0] OP_LUI     = 6'd20;
    localparam logic [IOPBITS-1:0] OP_AUIPC   = 6'd21;
    localparam logic [IOPBITS-1:0] OP_LW      = 6'd22;
    localparam logic [IOPBITS-1:0] OP_SW      = 6'd23;
    localparam logic [IOPBITS-1:0] OP_BEQ     = 6'd24;
    localparam logic [IOPBITS-1:0] OP_BNE     = 6'd25;
    localparam logic [IOPBITS-1:0] OP_BLT     = 6'd26;
    localparam logic [IOPBITS-1:0] OP_BGE     = 6'd27;
    localparam logic [IOPBITS-1:0] OP_BLTU    = 6'd28;
    localparam logic [IOPBITS-1:0] OP_BGEU    = 6'd29;
    localparam logic [IOPBITS-1:0] OP_JAL     = 6'd30;
    localparam logic [IOPBITS-1:0] OP_JALR    = 6'd31;
    localparam logic [IOPBITS-1:0] OP_CSRR    = 6'd32;
    localparam logic [IOPBITS-1:0] OP_CSRW    = 6'd33;
    localparam logic [IOPBITS-1:0] OP_MUL     = 6'd34;

    localparam logic [TYPENOBITS-1:0] TYPE_INVALID = 3'd0;
    localparam logic [TYPENOBITS-1:0] TYPE_R       = 3'd1;
    localparam logic [TYPENOBITS-1:0] TYPE_I       = 3'd2;
    localparam logic [TYPENOBITS-1:0] TYPE_S       = 3'd3;
    localparam logic [TYPENOBITS-1:0] TYPE_B       = 3'd4;
    localparam logic [TYPENOBITS-1:0] TYPE_U       = 3'd5;
    localparam logic [TYPENOBITS-1:0] TYPE_J       = 3'd6;

    localparam logic [1:0] MUL_IDLE = 2'd0;
    localparam logic [1:0] MUL_BUSY = 2'd1;
    localparam logic [1:0] MUL_DONE = 2'd2;

    typedef struct packed {
        logic                  valid;
        logic [31:0]           inst;
        logic [DBITS-1:0]      pc;
        logic [DBITS-1:0]      pcplus;
        logic [IOPBITS-1:0]    op_I;
        logic [TYPENOBITS-1:0] type_I;
        logic [DBITS-1:0]      inst_count;
        logic [DBITS-1:0]      imm;
        logic [DBITS-1:0]      rs1_val;
        logic [DBITS-1:0]      rs2_val;
    } de_latch_t;

    typedef struct packed {
        logic                 valid;
        logic [31:0]          inst;
        logic [DBITS-1:0]     pc;
        logic [IOPBITS-1:0]   op_I;
        logic [DBITS-1:0]     inst_count;
        logic                 wr_reg;
        logic [REGNOBITS-1:0] rd;
        logic [DBITS-1:0]     result;
        logic [DBITS-1:0]     store_data;
    } agex_latch_t;

    localparam int DE_latch_WIDTH   = $bits(de_latch_t);
    localparam int AGEX_latch_WIDTH = $bits(agex_latch_t);

endpackage

// File: rtl/agex_stage_if.sv
// Decode-to-AGEX bus plus the redirect/hazard feedback that AGEX returns upstream.
interface agex_stage_if;
    import agex_stage_pkg::*;

    // from_DE_latch.valid qualifies the word; agex_busy acts as not-ready:
    // while it is high the producer must hold from_DE_latch unchanged.
    logic [DE_latch_WIDTH-1:0]   from_DE_latch;
    logic                        br_redirect;
    logic [DBITS-1:0]            br_target;
    logic                        agex_busy;
    logic [REGNOBITS-1:0]        rd_AGEX;
    logic [TYPENOBITS-1:0]       type_AGEX;
    logic [AGEX_latch_WIDTH-1:0] AGEX_latch_out;
    logic [1:0]                  mul_state_dbg;

    modport master (
        output from_DE_latch,
        input  br_redirect, br_target, agex_busy, rd_AGEX, type_AGEX,
        input  AGEX_latch_out, mul_state_dbg
    );

    modport slave (
        input  from_DE_latch,
        output br_redirect, br_target, agex_busy, rd_AGEX, type_AGEX,
        output AGEX_latch_out, mul_state_dbg
    );

endinterface

// File: rtl/agex_stage_mul_iter.sv
// Radix-2 shift-add multiplier producing the low DBITS bits of the product, one bit per cycle.
module agex_mul_iter
    import agex_stage_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DBITS-1:0] op_a,
    input  logic [DBITS-1:0] op_b,
    output logic [DBITS-1:0] product,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);
    logic [1:0]         state_q, state_d;
    logic [CNTBITS-1:0] cnt_q, cnt_d;
    logic [DBITS-1:0]   mcand_q, mcand_d;
    logic [DBITS-1:0]   mplier_q, mplier_d;
    logic [DBITS-1:0]   acc_q, acc_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        case (state_q)
            MUL_IDLE: begin
                if (start) begin
                    state_d  = MUL_BUSY;
                    cnt_d    = '0;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_d    = '0;
                end
            end
            MUL_BUSY: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNTBITS'(DBITS - 1)) state_d = MUL_DONE;
            end
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= MUL_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    // Busy already in the start cycle so upstream stalls before operands are captured.
    assign busy      = ((state_q == MUL_IDLE) && start) || (state_q == MUL_BUSY);
    assign done      = (state_q == MUL_DONE);
    assign product   = acc_q;
    assign state_dbg = state_q;

endmodule

// File: rtl/agex_stage.sv
// Execute/address-generation stage: ALU, branch resolution, iterative MUL and the AGEX latch.
module agex_stage
    import agex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    agex_stage_if.slave bus
);
    de_latch_t            de;
    agex_latch_t          latch_q, latch_d;
    logic [DBITS-1:0]     alu_result, br_target_c, jalr_sum, mul_product;
    logic [REGNOBITS-1:0] rd;
    logic [SHBITS-1:0]    shamt_r, shamt_i;
    logic                 taken, wr_reg, mul_start, mul_busy, mul_done;
    logic [1:0]           mul_state;

    assign de       = de_latch_t'(bus.from_DE_latch);
    assign rd       = de.inst[7 +: REGNOBITS];
    assign shamt_r  = de.rs2_val[SHBITS-1:0];
    assign shamt_i  = de.imm[SHBITS-1:0];
    assign jalr_sum = de.rs1_val + de.imm;

    always_comb begin
        alu_result  = '0;
        taken       = 1'b0;
        br_target_c = de.pc + de.imm;
        case (de.op_I)
            OP_ADD:   alu_result = de.rs1_val + de.rs2_val;
            OP_SUB:   alu_result = de.rs1_val - de.rs2_val;
            OP_AND:   alu_result = de.rs1_val & de.rs2_val;
            OP_OR:    alu_result = de.rs1_val | de.rs2_val;
            OP_XOR:   alu_result = de.rs1_val ^ de.rs2_val;
            OP_SLT:   alu_result = {{(DBITS-1){1'b0}}, $signed(de.rs1_val) < $signed(de.rs2_val)};
            OP_SLTU:  alu_result = {{(DBITS-1){1'b0}}, de.rs1_val < de.rs2_val};
            OP_SLL:   alu_result = de.rs1_val << shamt_r;
            OP_SRL:   alu_result = de.rs1_val >> shamt_r;
            OP_SRA:   alu_result = $signed(de.rs1_val) >>> shamt_r;
            OP_ADDI:  alu_result = de.rs1_val + de.imm;
            OP_ANDI:  alu_result = de.rs1_val & de.imm;
            OP_ORI:   alu_result = de.rs1_val | de.imm;
            OP_XORI:  alu_result = de.rs1_val ^ de.imm;
            OP_SLTI:  alu_result = {{(DBITS-1){1'b0}}, $signed(de.rs1_val) < $signed(de.imm)};
            OP_SLTIU: alu_result = {{(DBITS-1){1'b0}}, de.rs1_val < de.imm};
            OP_SLLI:  alu_result = de.rs1_val << shamt_i;
            OP_SRLI:  alu_result = de.rs1_val >> shamt_i;
            OP_SRAI:  alu_result = $signed(de.rs1_val) >>> shamt_i;
            OP_LUI:   alu_result = de.imm;
            OP_AUIPC: alu_result = de.pc + de.imm;
            OP_LW:    alu_result = de.rs1_val + de.imm;
            OP_SW:    alu_result = de.rs1_val + de.imm;
            OP_BEQ:   taken = (de.rs1_val == de.rs2_val);
            OP_BNE:   taken = (de.rs1_val != de.rs2_val);
            OP_BLT:   taken = ($signed(de.rs1_val) <  $signed(de.rs2_val));
            OP_BGE:   taken = ($signed(de.rs1_val) >= $signed(de.rs2_val));
            OP_BLTU:  taken = (de.rs1_val <  de.rs2_val);
            OP_BGEU:  taken = (de.rs1_val >= de.rs2_val);
            OP_JAL: begin
                alu_result = de.pcplus;
                taken      = 1'b1;
            end
            OP_JALR: begin
                alu_result  = de.pcplus;
                taken       = 1'b1;
                br_target_c = {jalr_sum[DBITS-1:1], 1'b0};
            end
            OP_CSRR:  alu_result = de.rs1_val;
            OP_CSRW:  alu_result = de.rs1_val;
            default:  alu_result = '0;
        endcase
    end

    assign wr_reg = (rd != '0) && (de.op_I != OP_INVALID) &&
                    ((de.type_I == TYPE_R) || (de.type_I == TYPE_I) ||
                     (de.type_I == TYPE_U) || (de.type_I == TYPE_J));

    assign mul_start = de.valid && (de.op_I == OP_MUL);

    agex_mul_iter u_mul (
        .clk       (clk),
        .reset     (reset),
        .start     (mul_start),
        .op_a      (de.rs1_val),
        .op_b      (de.rs2_val),
        .product   (mul_product),
        .busy      (mul_busy),
        .done      (mul_done),
        .state_dbg (mul_state)
    );

    // A held MUL only reaches the latch in its DONE cycle, when busy has dropped.
    always_comb begin
        latch_d = '0;
        if (de.valid && !mul_busy) begin
            latch_d.valid      = 1'b1;
            latch_d.inst       = de.inst;
            latch_d.pc         = de.pc;
            latch_d.op_I       = de.op_I;
            latch_d.inst_count = de.inst_count;
            latch_d.wr_reg     = wr_reg;
            latch_d.rd         = rd;
            latch_d.result     = mul_done ? mul_product : alu_result;
            latch_d.store_data = de.rs2_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) latch_q <= '0;
        else       latch_q <= latch_d;
    end

    assign bus.br_redirect    = de.valid && taken;
    assign bus.br_target      = br_target_c;
    assign bus.agex_busy      = mul_busy;
    assign bus.rd_AGEX        = de.valid ? rd : '0;
    assign bus.type_AGEX      = de.valid ? de.type_I : '0;
    assign bus.AGEX_latch_out = latch_q;
    assign bus.mul_state_dbg  = mul_state;

endmodule

// File: tb/tb_agex_stage.sv
// Randomized bench for agex_stage against an arithmetic reference model and result queue.
module tb_agex_stage;
    import agex_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    agex_stage_if bus ();
    agex_stage dut (.clk(clk), .reset(reset), .bus(bus));

    de_latch_t   de;
    agex_latch_t lat;
    assign bus.from_DE_latch = de;
    assign lat = agex_latch_t'(bus.AGEX_latch_out);

    int n_tests = 0;
    int n_fail  = 0;
    logic [DBITS-1:0] exp_q[$];
    bit               chk_q[$];
    logic [IOPBITS-1:0] op_list [0:33];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TYPENOBITS-1:0] op_type(input logic [IOPBITS-1:0] op);
        if (op == OP_INVALID) return TYPE_INVALID;
        if ((op >= OP_ADD && op <= OP_SRA) || op == OP_MUL) return TYPE_R;
        if (op == OP_SW) return TYPE_S;
        if (op >= OP_BEQ && op <= OP_BGEU) return TYPE_B;
        if (op == OP_LUI || op == OP_AUIPC) return TYPE_U;
        if (op == OP_JAL) return TYPE_J;
        return TYPE_I;
    endfunction

    function automatic bit writes_rd(input logic [IOPBITS-1:0] op);
        return !(op == OP_INVALID || op == OP_SW || (op >= OP_BEQ && op <= OP_BGEU));
    endfunction

    // Reference semantics; chk = 0 where the result value is not architecturally defined.
    task automatic ref_exec(input logic [IOPBITS-1:0] op, input logic [31:0] pc, imm, a, b,
                            output logic [31:0] res, output bit chk, output bit redir,
                            output logic [31:0] tgt);
        res = 0; chk = 1; redir = 0; tgt = pc + imm;
        case (op)
            OP_ADD:   res = a + b;
            OP_SUB:   res = a - b;
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            OP_XOR:   res = a ^ b;
            OP_SLT:   res = ($signed(a) < $signed(b)) ? 1 : 0;
            OP_SLTU:  res = (a < b) ? 1 : 0;
            OP_SLL:   res = a << (b % 32);
            OP_SRL:   res = a >> (b % 32);
            OP_SRA:   res = $signed(a) >>> (b % 32);
            OP_ADDI:  res = a + imm;
            OP_ANDI:  res = a & imm;
            OP_ORI:   res = a | imm;
            OP_XORI:  res = a ^ imm;
            OP_SLTI:  res = ($signed(a) < $signed(imm)) ? 1 : 0;
            OP_SLTIU: res = (a < imm) ? 1 : 0;
            OP_SLLI:  res = a << (imm % 32);
            OP_SRLI:  res = a >> (imm % 32);
            OP_SRAI:  res = $signed(a) >>> (imm % 32);
            OP_LUI:   res = imm;
            OP_AUIPC: res = pc + imm;
            OP_LW, OP_SW: res = a + imm;
            OP_BEQ:   begin chk = 0; redir = (a == b); end
            OP_BNE:   begin chk = 0; redir = (a != b); end
            OP_BLT:   begin chk = 0; redir = ($signed(a) <  $signed(b)); end
            OP_BGE:   begin chk = 0; redir = ($signed(a) >= $signed(b)); end
            OP_BLTU:  begin chk = 0; redir = (a <  b); end
            OP_BGEU:  begin chk = 0; redir = (a >= b); end
            OP_JAL:   begin res = pc + 4; redir = 1; end
            OP_JALR:  begin res = pc + 4; redir = 1; tgt = (a + imm) & 32'hFFFF_FFFE; end
            OP_CSRR, OP_CSRW: res = a;
            OP_MUL:   res = a * b;
            default:  res = 0;
        endcase
    endtask

    task automatic set_de(input logic [IOPBITS-1:0] op, input logic [31:0] pc, imm, a, b,
                          input logic [4:0] rd);
        de.valid      = 1'b1;
        de.inst       = {12'($urandom), 5'($urandom), 3'($urandom), rd, 7'($urandom)};
        de.pc         = pc;
        de.pcplus     = pc + 4;
        de.op_I       = op;
        de.type_I     = op_type(op);
        de.inst_count = $urandom;
        de.imm        = imm;
        de.rs1_val    = a;
        de.rs2_val    = b;
    endtask

    task automatic run_one(input logic [IOPBITS-1:0] op, input logic [31:0] pc, imm, a, b,
                           input logic [4:0] rd);
        logic [31:0] e_res, e_tgt, q_res;
        bit e_chk, e_redir, q_chk;
        set_de(op, pc, imm, a, b, rd);
        ref_exec(op, pc, imm, a, b, e_res, e_chk, e_redir, e_tgt);
        exp_q.push_back(e_res);
        chk_q.push_back(e_chk);
        @(negedge clk);
        check("redirect", 64'(bus.br_redirect), 64'(e_redir));
        if (e_redir) check("br_target", 64'(bus.br_target), 64'(e_tgt));
        check("busy", 64'(bus.agex_busy), 64'(0));
        check("type_agex", 64'(bus.type_AGEX), 64'(op_type(op)));
        check("rd_agex", 64'(bus.rd_AGEX), 64'(rd));
        @(posedge clk); #1;
        check("lat_valid", 64'(lat.valid), 64'(1));
        q_res = exp_q.pop_front();
        q_chk = chk_q.pop_front();
        if (q_chk) check("lat_result", 64'(lat.result), 64'(q_res));
        check("lat_wr_reg", 64'(lat.wr_reg), 64'(writes_rd(op) && rd != 0));
        check("lat_rd", 64'(lat.rd), 64'(rd));
        check("lat_pc", 64'(lat.pc), 64'(pc));
        check("lat_icount", 64'(lat.inst_count), 64'(de.inst_count));
        if (op == OP_SW) check("store_data", 64'(lat.store_data), 64'(b));
    endtask

    task automatic run_bubble();
        de       = '0;
        de.op_I  = OP_JAL;
        de.type_I = TYPE_J;
        @(negedge clk);
        check("bub_redirect", 64'(bus.br_redirect), 64'(0));
        check("bub_type", 64'(bus.type_AGEX), 64'(0));
        @(posedge clk); #1;
        check("bub_lat_valid", 64'(lat.valid), 64'(0));
    endtask

    task automatic run_mul(input logic [31:0] a, b, input logic [4:0] rd);
        logic [31:0] e_res, e_tgt;
        bit e_chk, e_redir, got;
        int busy_n, bubbles;
        busy_n = 0; bubbles = 0; got = 0;
        set_de(OP_MUL, 32'h200, 32'h0, a, b, rd);
        ref_exec(OP_MUL, 32'h200, 32'h0, a, b, e_res, e_chk, e_redir, e_tgt);
        exp_q.push_back(e_res);
        for (int c = 0; c < DBITS + 10 && !got; c++) begin
            @(negedge clk);
            if (bus.agex_busy) busy_n++;
            check("mul_type_agex", 64'(bus.type_AGEX), 64'(TYPE_R));
            @(posedge clk); #1;
            if (lat.valid) begin
                got = 1;
                check("mul_result", 64'(lat.result), 64'(exp_q.pop_front()));
                check("mul_rd", 64'(lat.rd), 64'(rd));
            end else begin
                bubbles++;
            end
        end
        check("mul_completed", 64'(got), 64'(1));
        check("mul_busy_cycles", 64'(busy_n), 64'(DBITS + 1));
        check("mul_latency", 64'(bubbles + 1), 64'(DBITS + 2));
        if (!got) void'(exp_q.pop_front());
        de.valid = 1'b0;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        op_list = '{OP_INVALID, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU,
                    OP_SLL, OP_SRL, OP_SRA, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI,
                    OP_SLTIU, OP_SLLI, OP_SRLI, OP_SRAI, OP_LUI, OP_AUIPC, OP_LW, OP_SW,
                    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_JAL, OP_JALR,
                    OP_CSRR, OP_CSRW};
        de    = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_latch_zero", 64'(|bus.AGEX_latch_out), 64'(0));
        check("rst_busy", 64'(bus.agex_busy), 64'(0));
        check("rst_redirect", 64'(bus.br_redirect), 64'(0));
        check("rst_type", 64'(bus.type_AGEX), 64'(0));
        check("rst_state", 64'(bus.mul_state_dbg), 64'(MUL_IDLE));

        run_one(OP_ADDI, 32'h80, 32'h1, 32'hFFFF_FFFF, 32'h0, 5'd3);
        run_one(OP_BLT,  32'h100, 32'h20, 32'hFFFF_FFFE, 32'h1, 5'd0);
        run_one(OP_BLTU, 32'h100, 32'h20, 32'hFFFF_FFFE, 32'h1, 5'd0);
        run_one(OP_JALR, 32'h40, 32'h10, 32'h205, 32'h0, 5'd1);
        run_one(OP_SW,   32'h60, 32'hFFFF_FFFC, 32'h1000, 32'hDEAD, 5'd4);
        run_one(OP_SRA,  32'h64, 32'h0, 32'h8000_0000, 32'h24, 5'd5);
        run_one(OP_INVALID, 32'h68, 32'h5, 32'h7, 32'h9, 5'd6);
        run_bubble();

        run_mul(32'h1234_5678, 32'h10, 5'd7);
        run_one(OP_ADD, 32'h300, 32'h0, 32'h5, 32'h6, 5'd8);

        for (int i = 0; i < 160; i++) begin
            logic [IOPBITS-1:0] op;
            logic [31:0] a, b;
            op = op_list[$urandom_range(0, 33)];
            a  = rnd_val();
            b  = ($urandom_range(0, 4) == 0) ? a : rnd_val();
            if ($urandom_range(0, 9) == 0) run_bubble();
            else run_one(op, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, rnd_val(), a, b,
                         5'($urandom_range(0, 31)));
            if (i % 50 == 25) run_mul(rnd_val(), $urandom, 5'($urandom_range(1, 31)));
        end

        begin
            int late_valid;
            late_valid = 0;
            set_de(OP_MUL, 32'h400, 32'h0, 32'h3, 32'h5, 5'd9);
            repeat (10) @(posedge clk);
            #1;
            check("abort_pre_state", 64'(bus.mul_state_dbg), 64'(MUL_BUSY));
            check("abort_pre_busy", 64'(bus.agex_busy), 64'(1));
            reset    = 1'b1;
            de.valid = 1'b0;
            @(posedge clk); #1;
            reset = 1'b0;
            check("abort_busy", 64'(bus.agex_busy), 64'(0));
            check("abort_latch_zero", 64'(|bus.AGEX_latch_out), 64'(0));
            check("abort_state", 64'(bus.mul_state_dbg), 64'(MUL_IDLE));
            repeat (DBITS + 4) begin
                @(posedge clk); #1;
                if (lat.valid) late_valid++;
            end
            check("abort_no_result", 64'(late_valid), 64'(0));
        end

        run_one(OP_XORI, 32'h500, 32'h0F0F_0F0F, 32'hFF00_FF00, 32'h0, 5'd10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
